// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state encoding and memory access size codes
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter between IF fetches and MEM loads/stores
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [1:0]        mem_size,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [1:0]        ram_size,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       if_rdata,
  output logic [31:0]       mem_rdata,
  output logic              if_valid,
  output logic              mem_valid,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic [1:0] ram_size_q, ram_size_d;
  logic if_valid_q, if_valid_d, mem_valid_q, mem_valid_d, flush_q, flush_d;
  logic mem_go, if_go, if_drop;
  assign mem_go = (mem_rd_req | mem_wr_req) & ~mem_valid_q;
  assign if_go = if_req & ~if_valid_q;
  assign if_drop = flush_q | if_flush;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ram_en_d = ram_en_q;
    ram_we_d = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_size_d = ram_size_q;
    if_rdata_d = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d = 1'b0;
    mem_valid_d = 1'b0;
    flush_d = flush_q;
    if (state_q == IDLE) begin
      if (mem_go) begin
        state_d = MEM_BUSY;
        cnt_d = CNT_LOAD;
        ram_en_d = 1'b1;
        ram_we_d = mem_wr_req;
        ram_addr_d = mem_addr;
        ram_wdata_d = mem_wdata;
        ram_size_d = mem_size;
      end else if (if_go) begin
        state_d = IF_BUSY;
        cnt_d = CNT_LOAD;
        ram_en_d = 1'b1;
        ram_we_d = 1'b0;
        ram_addr_d = if_addr;
        ram_size_d = SIZE_WORD;
        flush_d = 1'b0;
      end
    end else if (cnt_q == 4'd0) begin
      state_d = IDLE;
      ram_en_d = 1'b0;
      ram_we_d = 1'b0;
      if (state_q == MEM_BUSY) begin
        mem_valid_d = 1'b1;
        mem_rdata_d = ram_we_q ? mem_rdata_q : ram_rdata;
      end else begin
        if_valid_d = ~if_drop;
        if_rdata_d = if_drop ? if_rdata_q : ram_rdata;
        flush_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      flush_d = flush_q | ((state_q == IF_BUSY) & if_flush);
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      ram_size_q <= SIZE_WORD;
      if_rdata_q <= '0;
      mem_rdata_q <= '0;
      if_valid_q <= 1'b0;
      mem_valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_size_q <= ram_size_d;
      if_rdata_q <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      flush_q <= flush_d;
    end
  end
  assign ram_en = ram_en_q;
  assign ram_we = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_size = ram_size_q;
  assign if_rdata = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_valid = if_valid_q;
  assign mem_valid = mem_valid_q;
  assign stall_if = if_req & ~if_valid_q;
  assign stall_mem = (mem_rd_req | mem_wr_req) & ~mem_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic Clk = 1'b0, Rst = 1'b1;
  logic if_req = 1'b0, if_flush = 1'b0, mem_rd_req = 1'b0, mem_wr_req = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
  logic [1:0] mem_size = '0;
  logic ram_en, ram_we, if_valid, mem_valid, stall_if, stall_mem;
  logic [31:0] ram_addr, ram_wdata, if_rdata, mem_rdata;
  logic [1:0] ram_size;
  int total = 0, bad = 0;
  mem_port_arbiter dut (
    .Clk(Clk), .Rst(Rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_size(ram_size), .ram_rdata(ram_rdata),
    .if_rdata(if_rdata), .mem_rdata(mem_rdata), .if_valid(if_valid), .mem_valid(mem_valid),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_size", ram_size, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_valids", {if_valid, mem_valid}, 0);
    Rst = 1'b0;
    #1;
    chk("idle_stalls", {stall_if, stall_mem}, 0);
    if_req = 1'b1; if_addr = 32'h40; ram_rdata = 32'h8C220004;
    #1;
    chk("if_stall", stall_if, 1);
    step();
    chk("if_en1", ram_en, 1);
    chk("if_cmd", {ram_we, ram_size, ram_addr}, {1'b0, 2'b00, 32'h40});
    step();
    chk("if_en2", ram_en, 1);
    chk("if_novalid", if_valid, 0);
    step();
    chk("if_en_off", ram_en, 0);
    chk("if_valid", if_valid, 1);
    chk("if_rdata", if_rdata, 32'h8C220004);
    chk("if_stall_off", stall_if, 0);
    if_req = 1'b0;
    step();
    chk("if_pulse", if_valid, 0);
    if_req = 1'b1; if_addr = 32'h44;
    mem_rd_req = 1'b1; mem_addr = 32'h100; mem_size = 2'b00; ram_rdata = 32'h11112222;
    step();
    chk("pri_addr", ram_addr, 32'h100);
    chk("pri_stalls", {stall_if, stall_mem}, 2'b11);
    step();
    step();
    chk("pri_mem_valid", mem_valid, 1);
    chk("pri_mem_rdata", mem_rdata, 32'h11112222);
    chk("pri_gap", ram_en, 0);
    mem_rd_req = 1'b0; ram_rdata = 32'h33334444;
    step();
    chk("pri_if_grant", {ram_en, ram_addr}, {1'b1, 32'h44});
    chk("pri_mem_pulse", mem_valid, 0);
    step();
    chk("pri_if_wait", if_valid, 0);
    step();
    chk("pri_if_valid", if_valid, 1);
    chk("pri_if_rdata", if_rdata, 32'h33334444);
    if_req = 1'b0;
    step();
    mem_wr_req = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF; mem_size = 2'b10;
    ram_rdata = 32'h55555555;
    step();
    chk("st_cmd1", {ram_en, ram_we, ram_size, ram_addr, ram_wdata},
        {1'b1, 1'b1, 2'b10, 32'h200, 32'hDEADBEEF});
    step();
    chk("st_cmd2", {ram_en, ram_we, ram_size}, {1'b1, 1'b1, 2'b10});
    step();
    chk("st_ack", mem_valid, 1);
    chk("st_rdata_kept", mem_rdata, 32'h11112222);
    mem_wr_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h80; ram_rdata = 32'h66666666;
    step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    step();
    chk("fl_no_valid", if_valid, 0);
    chk("fl_rdata_kept", if_rdata, 32'h33334444);
    chk("fl_en_off", ram_en, 0);
    if_addr = 32'h84; ram_rdata = 32'h77777777;
    step();
    chk("fl_regrant", {ram_en, ram_addr}, {1'b1, 32'h84});
    step();
    step();
    chk("fl_next_valid", if_valid, 1);
    chk("fl_next_rdata", if_rdata, 32'h77777777);
    if_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h90; ram_rdata = 32'h99990000;
    step();
    mem_rd_req = 1'b1; mem_addr = 32'h140; ram_rdata = 32'hAAAA0000;
    step();
    chk("wait_if_addr", ram_addr, 32'h90);
    step();
    chk("wait_if_valid", if_valid, 1);
    chk("wait_if_rdata", if_rdata, 32'hAAAA0000);
    if_req = 1'b0; ram_rdata = 32'hBBBB0000;
    step();
    chk("wait_mem_grant", {ram_en, ram_addr}, {1'b1, 32'h140});
    step();
    step();
    chk("wait_mem_valid", {mem_valid, mem_rdata}, {1'b1, 32'hBBBB0000});
    mem_rd_req = 1'b0;
    step();
    mem_rd_req = 1'b1; mem_addr = 32'h300; ram_rdata = 32'h88888888;
    step();
    step();
    Rst = 1'b1;
    step();
    chk("rst_mid_en", {ram_en, ram_we, ram_size}, 0);
    chk("rst_mid_addr", ram_addr, 0);
    chk("rst_mid_valid", {if_valid, mem_valid}, 0);
    chk("rst_mid_rdata", {if_rdata, mem_rdata}, 0);
    Rst = 1'b0;
    step();
    chk("rst_regrant", {ram_en, ram_addr}, {1'b1, 32'h300});
    step();
    step();
    chk("rst_re_valid", {mem_valid, mem_rdata}, {1'b1, 32'h88888888});
    mem_rd_req = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The parameter LATENCY SHALL default to 2 and set the memory access time in cycles (legal range 1..15).
REQ-002 The parameter ADDR_W SHALL default to 32 and set the address width.
REQ-003 The port Clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 The port Rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 The port if_req SHALL be an input, 1 bit wide: fetch request, held high until if_valid.
REQ-006 The port if_addr SHALL be an input, ADDR_W bits wide: the fetch address.
REQ-007 The port if_flush SHALL be an input, 1 bit wide: discard the in-flight fetch result.
REQ-008 The ports mem_rd_req and mem_wr_req SHALL be inputs, 1 bit wide each: load or store request from the MEM stage, held until mem_valid; never both high.
REQ-009 The ports mem_addr, mem_wdata and mem_size SHALL be inputs of ADDR_W, 32 and 2 bits respectively: load/store address, store data and size (00 word, 01 half, 10 byte).
REQ-010 The ports ram_en, ram_we, ram_addr, ram_wdata and ram_size SHALL be outputs of 1, 1, ADDR_W, 32 and 2 bits respectively: the single-port memory command, all registered.
REQ-011 The port ram_rdata SHALL be an input, 32 bits wide: memory read data, valid in the final access cycle.
REQ-012 The ports if_rdata and mem_rdata SHALL be outputs, 32 bits wide each: registered return data.
REQ-013 The ports if_valid and mem_valid SHALL be outputs, 1 bit wide each: one-cycle completion pulses.
REQ-014 The ports stall_if and stall_mem SHALL be outputs, 1 bit wide each: hold the IF, or the IF..MEM stages, respectively.

Function
REQ-015 The FSM SHALL have three states: IDLE, IF_BUSY and MEM_BUSY.
REQ-016 In IDLE with mem_rd_req or mem_wr_req high, the FSM SHALL go next to MEM_BUSY; otherwise, with if_req high, it SHALL go to IF_BUSY. MEM has fixed priority over IF.
REQ-017 On grant, the block SHALL register ram_en=1, ram_addr, ram_size and ram_we/ram_wdata (MEM) from the granted requester and hold them constant for LATENCY cycles.
REQ-018 An IF grant SHALL drive ram_we=0 and ram_size=00.
REQ-019 A 4-bit down-counter SHALL load LATENCY-1 on grant; the access completes in the busy cycle where the count is 0.
REQ-020 At completion, the block SHALL capture ram_rdata into if_rdata or mem_rdata, pulse the matching valid for one cycle, deassert ram_en and return to IDLE.
REQ-021 Request seen in IDLE at cycle t SHALL yield ram_en high from t+1 to t+LATENCY and valid at t+LATENCY+1.
REQ-022 No new grant SHALL be issued in the cycle a valid pulses; back-to-back accesses are therefore separated by one IDLE cycle.
REQ-023 A store SHALL pulse mem_valid as its acknowledge; mem_rdata SHALL be unchanged by a store.
REQ-024 stall_if SHALL equal if_req & ~if_valid, and stall_mem SHALL equal (mem_rd_req|mem_wr_req) & ~mem_valid, both combinational.
REQ-025 if_flush high during IF_BUSY or at its completion SHALL suppress that if_valid; the memory access still runs to completion.
REQ-026 A request dropped mid-access SHALL NOT abort the access; valid still pulses and the requester ignores it.
REQ-027 A MEM request arriving during IF_BUSY SHALL wait for the fetch to complete and then win the next IDLE arbitration.

Reset
REQ-028 Rst SHALL force, at the next edge: state IDLE, counter 0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, ram_size=00, if_rdata=0, mem_rdata=0, if_valid=0, mem_valid=0 and the flush flag cleared.
REQ-029 Rst asserted mid-access SHALL abandon the access with no valid pulse; the first grant is allowed in the cycle after Rst deasserts.

Structure
REQ-030 The state encoding and the size codes (00 word, 01 half, 10 byte) SHALL live in the shared pipeline package, reused by stage_MEM.
REQ-031 The block SHALL be a single module with no sub-module; the latency counter is inline.

Verification
REQ-032 IF only, LATENCY=2: if_req=1, if_addr=0x40, ram_rdata=0x8C220004 -> ram_en high 2 cycles, if_valid at t+3, if_rdata=0x8C220004.
REQ-033 Simultaneous: if_req with addr 0x44 and mem_rd_req with addr 0x100 at the same cycle -> MEM served first, mem_valid at t+3; IF granted at t+4, if_valid at t+6.
REQ-034 Store: mem_wr_req, addr 0x200, wdata 0xDEADBEEF, size 10 -> ram_we=1, ram_size=10 for 2 cycles, then mem_valid; mem_rdata unchanged.
REQ-035 Flush: if_flush pulsed during IF_BUSY -> no if_valid pulse; the next if_req is served normally.
REQ-036 Rst pulsed in the 2nd cycle of MEM_BUSY -> all outputs zero next edge, no mem_valid; a held request is re-granted after Rst drops.
